bam_mul_arbiter: RTL

Shared-access controller for one 8x8 unsigned broken-array approximate multiplier (horizontal cut 5, vertical cut 9; flat netlist `f_u_arrbam8_h5_v9`).
- Arbitrates up to NREQ requesters round-robin with valid/ready handshakes.
- Feeds the single multiplier instance through a 2-stage pipeline.
- Keeps one product accumulator per requester.
- Returns each tagged result on a single output channel with backpressure.

---
 rtl/bam_mul_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bam_mul_arbiter.sv
// bam_mul_arbiter: round-robin shared access to one 8x8 unsigned broken-array
// approximate multiplier (horizontal cut 5, vertical cut 9). It has a two-stage
// pipeline and one product accumulator per requester. Tagged results leave on a
// single output channel that supports backpressure.
module bam_mul_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int ACC_W = 20,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]     req_acc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDW-1:0]      out_id,
  output logic [15:0]         out_p,
  output logic [ACC_W-1:0]    out_data
);

  localparam int H_CUT = 5;  // rows b[0..H_CUT-1] are dropped
  localparam int V_CUT = 9;  // columns of weight below V_CUT are dropped
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  // (base + step) mod NREQ. The caller keeps base and step below NREQ,
  // so a single conditional subtract is enough.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input logic [IDW:0]   step);
    logic [IDW:0] sum;
    sum = {1'b0, base} + step;
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    return sum[IDW-1:0];
  endfunction

  // Broken-array product. Only the partial products a[i]&b[j] with j >= H_CUT
  // and i+j >= V_CUT survive, so bits [V_CUT-1:0] of the result are always 0.
  function automatic logic [15:0] bam_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int j = H_CUT; j < 8; j++) begin
      for (int i = 0; i < 8; i++) begin
        if (i + j >= V_CUT) p = p + (16'(a[i] & b[j]) << (i + j));
      end
    end
    return p;
  endfunction

  // Pipeline and arbitration state
  logic [IDW-1:0]   rr_q;
  logic             s1_valid_q;
  logic [IDW-1:0]   s1_id_q;
  logic [7:0]       s1_a_q;
  logic [7:0]       s1_b_q;
  logic             s1_acc_q;
  logic             s2_valid_q;
  logic [IDW-1:0]   s2_id_q;
  logic [15:0]      s2_p_q;
  logic [ACC_W-1:0] s2_data_q;
  logic [ACC_W-1:0] acc_q [NREQ];

  logic             s2_load;
  logic             grant_en;
  logic             found;
  logic             transfer;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;
  logic [NREQ-1:0]  grant;
  logic [7:0]       a_arr [NREQ];
  logic [7:0]       b_arr [NREQ];
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc_new;

  // Stall chain: S2 drains or is empty, S1 then moves up, and a grant is only
  // issued into an S1 slot that is free this cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  assign grant_en = !s1_valid_q || s2_load;

  // Rotating-priority search from rr upward. The operand slices are unpacked for muxing.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    grant    = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*8 +: 8];
      b_arr[i] = req_b[i*8 +: 8];
    end
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(rr_q, (IDW+1)'(k));
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    if (found && grant_en && !rst) grant[grant_id] = 1'b1;
  end

  assign req_ready = grant;
  assign transfer  = |grant;

  // Multiplier on S1 operands and the accumulator read-modify result
  assign prod    = bam_mul(s1_a_q, s1_b_q);
  assign acc_new = s1_acc_q ? acc_q[s1_id_q] + ACC_W'(prod) : ACC_W'(prod);

  // Round-robin pointer moves past the winner only on an actual transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else if (transfer) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // sample pre-edge values, independent of block evaluation order.
      rr_q <= wrap_add(grant_id, (IDW+1)'(1));
    end
  end

  // Stage 1 captures the granted request's operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_acc_q   <= 1'b0;
    end else if (grant_en) begin
      s1_valid_q <= transfer;
      if (transfer) begin
        s1_id_q  <= grant_id;
        s1_a_q   <= a_arr[grant_id];
        s1_b_q   <= b_arr[grant_id];
        s1_acc_q <= req_acc[grant_id];
      end
    end
  end

  // Stage 2 registers the product and writes back the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_p_q     <= '0;
      s2_data_q  <= '0;
      // NOTE: the accumulator bank is cleared on reset because a following
      // accumulate request must see zero. This makes it flops, not RAM.
      for (int i = 0; i < NREQ; i++) acc_q[i] <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_id_q         <= s1_id_q;
        s2_p_q          <= prod;
        s2_data_q       <= acc_new;
        acc_q[s1_id_q]  <= acc_new;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_id    = s2_id_q;
  assign out_p     = s2_p_q;
  assign out_data  = s2_data_q;

endmodule
